add_sched: RTL and testbench
============================

ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter W, default 10, operand/result width.
REQ-002 Parameter N, default 4, number of requesters (N >= 2).
REQ-003 Parameter LAT, default 2, adder latency in cycles from add_start to add_valid/add_y.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  N  per-requester operation request.
REQ-007 req_ready  output  N  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_a, req_b  input  N x W  per-requester operands.
REQ-009 rsp_valid  output  N  per-requester result available.
REQ-010 rsp_ready  input  N  per-requester result consumed.
REQ-011 rsp_y  output  N x W  per-requester result register.
REQ-012 add_start, add_a, add_b  output  1, W, W  drive to the shared adder.
REQ-013 add_y, add_valid  input  W, 1  from the shared adder.
REQ-014 err  output  1  sticky protocol-mismatch flag.

Function
REQ-015 Each requester has a slot state: IDLE, INFLT (in flight) or DONE (result held).
REQ-016 Slot transitions: IDLE->INFLT on grant; INFLT->DONE on result capture; DONE->IDLE on rsp_valid && rsp_ready; other events leave the state unchanged.
REQ-017 req_ready[i] is high only for the single granted requester in a cycle; the granted requester is in IDLE with req_valid high.
REQ-018 Arbitration is round-robin: the search starts at pointer p, and on a grant to i the pointer becomes (i+1) mod N; with no grant the pointer holds.
REQ-019 Arbitration is combinational on req_valid and slot state; at most one grant per cycle, and one grant per cycle is sustainable.
REQ-020 On a grant, add_start=1 and add_a/add_b equal the granted operands in the same cycle; otherwise add_start=0 and add_a/add_b=0.
REQ-021 A tag pipeline of LAT stages (valid bit plus requester index) advances every cycle; stage 0 loads {grant, index}.
REQ-022 When the last tag stage is valid, add_y is written into rsp_y[index] and that slot moves to DONE in the same edge.
REQ-023 rsp_valid[i] equals (slot i == DONE); rsp_y[i] is stable while rsp_valid[i] is high.
REQ-024 Minimum latency is LAT+1 edges: grant at edge t, rsp_valid high after edge t+LAT.
REQ-025 Result capture is keyed on the tag pipeline and never on add_valid alone.
REQ-026 err is set when add_valid differs from the last tag-stage valid bit in any cycle after reset; it clears only on reset.
REQ-027 A requester in DONE or INFLT is excluded from arbitration even if req_valid is high; there is no re-grant before rsp_ready.
REQ-028 Simultaneous capture for slot j and rsp handshake on slot k != j are both honoured in the same cycle.
REQ-029 All results are W bits; add_y is taken as-is and overflow wraps.

Reset
REQ-030 On rst_n low: all slots IDLE, pointer 0, tag pipeline cleared, rsp_y all 0, err 0; consequently req_ready, rsp_valid and add_start are 0.
REQ-031 Reset mid-operation discards in-flight tags; adder results arriving after reset release are ignored and do not set err while the adder itself is reset.

Structure
REQ-032 A shared package holds the slot-state enum (IDLE, INFLT, DONE) and the default values for W, N and LAT.
REQ-033 One sub-module, rr_arb (N-bit request, one-hot grant, pointer update), is instantiated; everything else is flat.

Verification
REQ-034 Single request: req0 a=3 b=4 at cycle 0 -> req_ready[0] at cycle 0, rsp_valid[0] after 3 edges with rsp_y[0]=7.
REQ-035 All four requesters valid at once, pointer 0 -> grants in order 0,1,2,3 on consecutive cycles; each rsp_y[i] is correct.
REQ-036 Wrap-around: a=1023 b=1 (W=10) -> rsp_y=0.
REQ-037 Backpressure: rsp_ready[1]=0 for 10 cycles while req_valid[1] stays high -> no second grant to 1, and rsp_y[1] is stable; others continue to be served.
REQ-038 Reset asserted one cycle after a grant -> all outputs are 0 after reset, no rsp_valid, and err=0.
REQ-039 add_valid is forced high with no tag in flight -> err=1 and stays 1 until reset.

Source files
------------

// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared slot-state type and default sizing for add_sched
package add_sched_pkg;

  localparam int W_DEF   = 10;
  localparam int N_DEF   = 4;
  localparam int LAT_DEF = 2;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_INFLT = 2'd1,
    SLOT_DONE  = 2'd2
  } slot_t;

endpackage

// File: rtl/add_sched_rr_arb.sv
// rtl/add_sched_rr_arb.sv - round-robin arbiter, one-hot grant with rotating priority pointer
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  int            j;

  // Search from the pointer upward (wrapping) and grant the first requester found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The requester after the winner gets top priority next; no grant keeps the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (any_grant) begin
      ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/add_sched.sv
// rtl/add_sched.sv - schedules N requesters onto one pipelined adder and holds per-requester results
module add_sched
  import add_sched_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int N   = N_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [N-1:0][W-1:0] req_a,
  input  logic [N-1:0][W-1:0] req_b,
  output logic [N-1:0]        rsp_valid,
  input  logic [N-1:0]        rsp_ready,
  output logic [N-1:0][W-1:0] rsp_y,
  output logic                add_start,
  output logic [W-1:0]        add_a,
  output logic [W-1:0]        add_b,
  input  logic [W-1:0]        add_y,
  input  logic                add_valid,
  output logic                err
);

  localparam int IW = $clog2(N);

  slot_t         slot_q [N];
  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          any_grant;

  logic [LAT-1:0] tag_v_q;
  logic [IW-1:0]  tag_idx_q [LAT];
  logic           cap_v;
  logic [IW-1:0]  cap_idx;

  // Only idle slots compete; a slot holding or awaiting a result cannot be re-granted.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE);
    end
  end

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (elig),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;
  assign cap_v     = tag_v_q[LAT-1];
  assign cap_idx   = tag_idx_q[LAT-1];

  // Launch the granted operands into the adder; the bus is zero when idle.
  always_comb begin
    add_start = any_grant;
    add_a     = '0;
    add_b     = '0;
    if (any_grant) begin
      add_a = req_a[grant_idx];
      add_b = req_b[grant_idx];
    end
  end

  // Tag pipeline mirrors the adder latency so the result can be routed to its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      for (int k = 0; k < LAT; k++) tag_idx_q[k] <= '0;
    end else begin
      tag_v_q[0]   <= any_grant;
      tag_idx_q[0] <= grant_idx;
      for (int k = 1; k < LAT; k++) begin
        tag_v_q[k]   <= tag_v_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
    end
  end

  // Per-slot lifecycle: grant -> in flight, tagged capture -> done, consumer handshake -> idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= SLOT_IDLE;
        rsp_y[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        case (slot_q[i])
          SLOT_IDLE:  if (grant[i]) slot_q[i] <= SLOT_INFLT;
          SLOT_INFLT: if (cap_v && (cap_idx == IW'(i))) begin
                        slot_q[i] <= SLOT_DONE;
                        rsp_y[i]  <= add_y;
                      end
          SLOT_DONE:  if (rsp_ready[i]) slot_q[i] <= SLOT_IDLE;
          default:    slot_q[i] <= SLOT_IDLE;
        endcase
      end
    end
  end

  // Result availability is purely the slot state, so rsp_y cannot change while offered.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      rsp_valid[i] = (slot_q[i] == SLOT_DONE);
    end
  end

  // Sticky flag whenever the adder's valid disagrees with what the tag pipeline expects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (add_valid != cap_v) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - scoreboard bench for add_sched with a behavioural pipelined adder
module tb_add_sched;

  localparam int W   = 10;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0]        rsp_valid;
  logic [N-1:0]        rsp_ready;
  logic [N-1:0][W-1:0] rsp_y;
  logic                add_start;
  logic [W-1:0]        add_a;
  logic [W-1:0]        add_b;
  logic [W-1:0]        add_y;
  logic                add_valid;
  logic                err;

  add_sched #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .add_valid (add_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural shared adder, reset together with the scheduler
  logic [LAT-1:0] av_pipe;
  logic [W-1:0]   ay_pipe [LAT];
  logic           force_av;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      av_pipe <= '0;
      for (int k = 0; k < LAT; k++) ay_pipe[k] <= '0;
    end else begin
      av_pipe[0] <= add_start;
      ay_pipe[0] <= add_a + add_b;
      for (int k = 1; k < LAT; k++) begin
        av_pipe[k] <= av_pipe[k-1];
        ay_pipe[k] <= ay_pipe[k-1];
      end
    end
  end

  assign add_valid = av_pipe[LAT-1] | force_av;
  assign add_y     = ay_pipe[LAT-1];

  typedef struct {
    int         idx;
    logic [W-1:0] y;
  } exp_t;

  exp_t   exp_q[$];
  int     grant_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     gcyc [N];
  logic [N-1:0] seen;
  bit     err_test = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: grant order, launch bus, result values, latency, stability, err
  initial begin
    int g;
    int k;
    seen = '0;
    for (int i = 0; i < N; i++) gcyc[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        grant_q.delete();
        seen = '0;
      end else begin
        checks++;
        if (add_start !== (|req_ready)) begin
          errors++;
          $display("FAIL add_start: got %0b, expected %0b", add_start, |req_ready);
        end
        for (int i = 0; i < N; i++) begin
          if (req_ready[IW'(i)] && !req_valid[IW'(i)]) begin
            errors++;
            $display("FAIL ready_without_valid: requester %0d ready=1, expected 0", i);
          end
          if (req_valid[IW'(i)] && req_ready[IW'(i)]) begin
            checks++;
            if (grant_q.size() == 0) begin
              errors++;
              $display("FAIL grant_order: got grant %0d, expected no grant", i);
            end else begin
              g = grant_q.pop_front();
              if (g != i) begin
                errors++;
                $display("FAIL grant_order: got grant %0d, expected %0d", i, g);
              end
            end
            checks++;
            if (add_a !== req_a[IW'(i)] || add_b !== req_b[IW'(i)]) begin
              errors++;
              $display("FAIL add_operands: got a=%0d b=%0d, expected a=%0d b=%0d",
                       add_a, add_b, req_a[IW'(i)], req_b[IW'(i)]);
            end
            gcyc[i] = cyc;
          end
          if (rsp_valid[IW'(i)]) begin
            k = -1;
            for (int e = exp_q.size() - 1; e >= 0; e--) begin
              if (exp_q[e].idx == i) k = e;
            end
            checks++;
            if (k < 0) begin
              errors++;
              $display("FAIL rsp_unexpected: requester %0d rsp_valid=1 y=%0d, expected no result", i, rsp_y[IW'(i)]);
            end else begin
              if (rsp_y[IW'(i)] !== exp_q[k].y) begin
                errors++;
                $display("FAIL rsp_y%0d: got %0d, expected %0d", i, rsp_y[IW'(i)], exp_q[k].y);
              end
              if (!seen[IW'(i)]) begin
                seen[IW'(i)] = 1'b1;
                checks++;
                if (cyc - gcyc[i] != LAT + 1) begin
                  errors++;
                  $display("FAIL latency%0d: got %0d edges, expected %0d", i, cyc - gcyc[i], LAT + 1);
                end
              end
              if (rsp_ready[IW'(i)]) begin
                exp_q.delete(k);
                seen[IW'(i)] = 1'b0;
              end
            end
          end
        end
        if (!err_test) begin
          checks++;
          if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_quiet: got %0b, expected 0", err);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_add_start"}, 64'(add_start), 64'd0);
    chk({tag, "_add_a"},     64'(add_a),     64'd0);
    chk({tag, "_add_b"},     64'(add_b),     64'd0);
    chk({tag, "_rsp_y"},     64'(rsp_y),     64'd0);
    chk({tag, "_err"},       64'(err),       64'd0);
  endtask

  task automatic issue(input int i, input int a, input int b);
    exp_t e;
    int   n;
    e.idx = i;
    e.y   = W'(a + b);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid[IW'(i)] = 1'b1;
    req_a[IW'(i)]     = W'(a);
    req_b[IW'(i)]     = W'(b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[IW'(i)] && n < 50);
    checks++;
    if (!req_ready[IW'(i)]) begin
      errors++;
      $display("FAIL issue_timeout%0d: got no req_ready, expected grant", i);
    end
    @(posedge clk); #1;
    req_valid[IW'(i)] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_results", 64'(exp_q.size()), 64'd0);
    chk("drain_grants",  64'(grant_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    force_av  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;

    // single request 3+4
    grant_q.push_back(0);
    issue(0, 3, 4);
    drain();

    // all four at once from pointer 0
    do_reset();
    grant_q.push_back(0);
    grant_q.push_back(1);
    grant_q.push_back(2);
    grant_q.push_back(3);
    fork
      issue(0, 10, 20);
      issue(1, 100, 200);
      issue(2, 500, 11);
      issue(3, 1000, 23);
    join
    drain();

    // overflow wraps
    grant_q.push_back(2);
    issue(2, 1023, 1);
    drain();

    // backpressure on requester 1 while it keeps requesting
    rsp_ready[1] = 1'b0;
    grant_q.push_back(1);
    issue(1, 5, 6);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("bp_rsp_valid1", 64'(rsp_valid[1]), 64'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_a[1]     = 10'd7;
    req_b[1]     = 10'd8;
    begin
      exp_t e;
      e.idx = 1;
      e.y   = 10'd15;
      exp_q.push_back(e);
    end
    grant_q.push_back(0);
    issue(0, 1, 2);
    grant_q.push_back(3);
    issue(3, 40, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_held_y1", 64'(rsp_y[1]), 64'd11);
    grant_q.push_back(1);
    rsp_ready[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[1] && n < 20);
    chk("bp_regrant1", 64'(req_ready[1]), 64'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // reset one cycle after a grant
    grant_q.push_back(3);
    issue(3, 9, 9);
    rst_n = 1'b0;
    #1;
    check_reset("midop");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_reset("post_midop");

    // spurious add_valid sets sticky err
    err_test = 1'b1;
    @(posedge clk); #1;
    force_av = 1'b1;
    @(posedge clk); #1;
    force_av = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", 64'(err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("err_reset", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    err_test = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
